// File: rtl/uart_bus_master.sv
// uart_bus_master: byte-stream (UART core) to peripheral-bus single-word read/write bridge
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_data, rx_avail   received byte and its valid flag from the UART core
//   rx_ack              one-cycle pulse consuming rx_data
//   tx_data, tx_wr      byte to send and its one-cycle strobe
//   tx_busy             UART transmitter busy
//   cs, addr, wr, rd    bus initiator controls
//   d_out, d_in         bus write data / registered read data (valid the cycle after cs&rd)
// Frames (MSB first): 'W' a3..a0 d3..d0 -> 'K'; 'R' a3..a0 -> d3..d0; other first bytes dropped.
// Optional macro UART_BUS_MASTER_TIMEOUT_EN: abandon a partial frame after TIMEOUT_CYCLES idle cycles.
module uart_bus_master #(
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_avail,
  output logic        rx_ack,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_busy,
  output logic        cs,
  output logic [31:0] addr,
  output logic        wr,
  output logic        rd,
  output logic [31:0] d_out,
  input  logic [31:0] d_in
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS_WR, BUS_RD, RD_WAIT, SEND, SEND_WAIT} state_t;
  state_t      state_q, state_d;
  logic        armed_q, armed_d;
  logic        is_wr_q, is_wr_d;
  logic        gap_q, gap_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [2:0]  left_q, left_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [31:0] addr_q, addr_d, dout_q, dout_d, rdata_q, rdata_d;
  logic        take;
  logic        unused_to;
  assign unused_to = (TIMEOUT_CYCLES > 0);
`ifdef UART_BUS_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
  always_ff @(posedge clk)
    to_q <= rst ? '0 : to_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      armed_q   <= 1'b1;
      is_wr_q   <= 1'b0;
      gap_q     <= 1'b0;
      cnt_q     <= '0;
      left_q    <= '0;
      tx_data_q <= '0;
      addr_q    <= '0;
      dout_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      is_wr_q   <= is_wr_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      tx_data_q <= tx_data_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      rdata_q   <= rdata_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    gap_d     = gap_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    tx_data_d = tx_data_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    rdata_d   = rdata_q;
    // Bytes are only taken while parsing; the armed flag re-arms on seeing rx_avail low.
    take      = rx_avail && armed_q && (state_q == IDLE || state_q == ADDR || state_q == WDATA);
    armed_d   = take ? 1'b0 : (!rx_avail ? 1'b1 : armed_q);
    rx_ack    = take;
    cs        = (state_q == BUS_WR) || (state_q == BUS_RD);
    wr        = state_q == BUS_WR;
    rd        = state_q == BUS_RD;
    tx_wr     = (state_q == SEND) && !tx_busy;
    case (state_q)
      IDLE: if (take && (rx_data == 8'h57 || rx_data == 8'h52)) begin
        is_wr_d = rx_data == 8'h57;
        cnt_d   = '0;
        state_d = ADDR;
      end
      ADDR: if (take) begin
        addr_d  = {addr_q[23:0], rx_data};
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? (is_wr_q ? WDATA : BUS_RD) : ADDR;
      end
      WDATA: if (take) begin
        dout_d  = {dout_q[23:0], rx_data};
        cnt_d   = cnt_q + 2'd1;
        state_d = cnt_q == 2'd3 ? BUS_WR : WDATA;
      end
      BUS_WR: begin
        tx_data_d = 8'h4B;
        left_d    = 3'd1;
        state_d   = SEND;
      end
      BUS_RD: state_d = RD_WAIT;
      // First response byte goes straight to tx_data; the rest queue in rdata.
      RD_WAIT: begin
        tx_data_d = d_in[31:24];
        rdata_d   = {d_in[23:0], 8'h00};
        left_d    = 3'd4;
        state_d   = SEND;
      end
      SEND: if (!tx_busy) begin
        gap_d   = 1'b1;
        state_d = SEND_WAIT;
      end
      // gap_q skips the cycle right after the strobe, before tx_busy can rise.
      SEND_WAIT: if (gap_q) gap_d = 1'b0;
      else if (!tx_busy) begin
        left_d = left_q - 3'd1;
        if (left_q != 3'd1) begin
          tx_data_d = rdata_q[31:24];
          rdata_d   = {rdata_q[23:0], 8'h00};
          state_d   = SEND;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    to_d = (take || !(state_q == ADDR || state_q == WDATA)) ? '0 : to_q + 1'b1;
    if (!take && to_q == TW'(TIMEOUT_CYCLES) && (state_q == ADDR || state_q == WDATA)) begin
      to_d    = '0;
      state_d = IDLE;
    end
`endif
  end
  assign tx_data = tx_data_q;
  assign addr    = addr_q;
  assign d_out   = dout_q;
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: scoreboard bench for uart_bus_master with UART-core and peripheral models
module tb_uart_bus_master;
  logic        clk = 0, rst = 1;
  logic [7:0]  rx_data = 0;
  logic        rx_avail = 0, tx_busy = 0;
  logic        rx_ack, tx_wr, cs, wr, rd;
  logic [7:0]  tx_data;
  logic [31:0] addr, d_out;
  logic [31:0] d_in = 32'hDEADBEEF, rd_val = 0;
  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} bus_t;
  bus_t        exp_bus[$];
  logic [7:0]  exp_tx[$];
  int          checks = 0, errors = 0, acks = 0, exp_acks = 0, busy_len = 2;
  uart_bus_master #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_avail(rx_avail), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy), .cs(cs), .addr(addr),
    .wr(wr), .rd(rd), .d_out(d_out), .d_in(d_in)
  );
  always #5 clk = ~clk;
  // Monitor: pops the scoreboard whenever the DUT strobes the bus or the transmitter.
  initial forever begin
    bus_t e;
    @(negedge clk);
    if (!rst) begin
      if (rx_ack) acks++;
      if (cs) begin
        checks++;
        if (rd == wr) begin errors++; $display("FAIL bus_strobe: rd=%b wr=%b, need exactly one", rd, wr); end
        else if (exp_bus.size() == 0) begin errors++; $display("FAIL bus_unexpected: got cs wr=%b addr=%h, none expected", wr, addr); end
        else begin
          e = exp_bus.pop_front();
          if (wr !== e.w || addr !== e.a || (e.w && d_out !== e.d)) begin
            errors++;
            $display("FAIL bus_cycle: got wr=%b addr=%h d_out=%h, need wr=%b addr=%h d_out=%h", wr, addr, d_out, e.w, e.a, e.d);
          end
        end
      end else if (rd || wr) begin checks++; errors++; $display("FAIL bus_strobe: rd=%b wr=%b without cs", rd, wr); end
      if (tx_wr) begin
        checks++;
        if (tx_busy) begin errors++; $display("FAIL tx_gate: tx_wr=1 while tx_busy=1, need tx_busy=0"); end
        else if (exp_tx.size() == 0) begin errors++; $display("FAIL tx_unexpected: got tx_data=%h, none expected", tx_data); end
        else begin
          logic [7:0] t;
          t = exp_tx.pop_front();
          if (tx_data !== t) begin errors++; $display("FAIL tx_byte: got %h need %h", tx_data, t); end
        end
      end
    end
  end
  // UART transmitter model: busy for a varying number of cycles after each strobe.
  initial forever begin
    @(negedge clk);
    if (tx_wr) begin
      @(posedge clk); #1 tx_busy = 1;
      repeat (busy_len) @(posedge clk);
      #1 tx_busy = 0;
      busy_len = busy_len % 4 + 1;
    end
  end
  // Peripheral model: read data valid only on the cycle after cs&rd.
  initial forever begin
    @(negedge clk);
    if (cs && rd) begin
      @(posedge clk); #1 d_in = rd_val;
      @(posedge clk); #1 d_in = 32'hDEADBEEF;
    end
  end
  task automatic send_byte(input logic [7:0] b, input int hold);
    int n = 0;
    rx_data = b; rx_avail = 1; exp_acks++;
    forever begin
      @(negedge clk);
      if (rx_ack) break;
      if (++n > 300) begin checks++; errors++; $display("FAIL rx_ack_timeout: byte %h never acknowledged, need rx_ack", b); break; end
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1 rx_avail = 0;
    @(posedge clk); #1;
  endtask
  task automatic send_w(input logic [31:0] a, input logic [31:0] d);
    exp_bus.push_back({1'b1, a, d}); exp_tx.push_back(8'h4B);
    send_byte(8'h57, 0);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 0);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 0);
  endtask
  task automatic send_r(input logic [31:0] a, input logic [31:0] v);
    exp_bus.push_back({1'b0, a, 32'h0});
    for (int i = 3; i >= 0; i--) exp_tx.push_back(v[i*8 +: 8]);
    send_byte(8'h52, 0);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], 0);
  endtask
  task automatic drain(input string name);
    int n = 0;
    while ((exp_bus.size() != 0 || exp_tx.size() != 0 || tx_busy) && n < 500) begin @(posedge clk); n++; end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_bus.size() != 0 || exp_tx.size() != 0) begin
      errors++; $display("FAIL %s_drain: got %0d bus / %0d tx outstanding, need 0 / 0", name, exp_bus.size(), exp_tx.size());
      exp_bus.delete(); exp_tx.delete();
    end
    checks++;
    if (acks != exp_acks) begin errors++; $display("FAIL %s_acks: got %0d rx_ack pulses, need %0d", name, acks, exp_acks); end
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if ({rx_ack, tx_wr, cs, rd, wr} !== 5'b0 || tx_data !== 8'h0 || addr !== 32'h0 || d_out !== 32'h0) begin
      errors++; $display("FAIL reset: got ack/txwr/cs/rd/wr=%b tx_data=%h addr=%h d_out=%h, need all 0", {rx_ack, tx_wr, cs, rd, wr}, tx_data, addr, d_out);
    end
    @(posedge clk); #1;
    send_w(32'h00000010, 32'h00000005);
    drain("write");
    rd_val = 32'h000000A5;
    send_r(32'h00000008, rd_val);
    drain("read");
    send_byte(8'h41, 0);
    drain("garbage");
    rd_val = 32'h12345678;
    send_r(32'h00000100, rd_val);
    drain("after_garbage");
    send_byte(8'h41, 5);
    drain("held");
    send_w(32'hA5A5F00F, 32'h80000001);
    drain("write2");
    send_byte(8'h57, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++;
    if (addr !== 32'h0 || cs) begin errors++; $display("FAIL mid_reset: got addr=%h cs=%b, need addr=0 cs=0", addr, cs); end
    @(posedge clk); #1;
    rd_val = 32'hCAFEF00D;
    send_r(32'h00000020, rd_val);
    drain("reset_then_read");
`ifdef UART_BUS_MASTER_TIMEOUT_EN
    send_byte(8'h52, 0);
    send_byte(8'h00, 0);
    repeat (110) @(posedge clk);
    #1;
    rd_val = 32'h0BADCAFE;
    send_r(32'h00000010, rd_val);
    drain("timeout");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, need completion");
    $fatal(1);
  end
endmodule
